composite_ecc_rx_pipe: RTL

Receive/check end of the composite ECC path. It accepts stored words as a Hamming(12,8)+overall-parity SECDED codeword plus the on-chip even-parity bit, and decodes them in a 2-stage valid/ready pipeline. Outputs are the corrected data, error classification, and saturating error counters. It sits between the memory read port and the consumer.

---
 rtl/composite_ecc_pkg.sv | 49 ++++
 rtl/composite_ecc_sat_counter.sv | 35 +++
 rtl/composite_ecc_rx_pipe.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/composite_ecc_pkg.sv
// composite_ecc_pkg: code geometry, data-bit positions, error classes,
// pipeline bundles and the data-extract helper for the SECDED receive pipe.
package composite_ecc_pkg;

    localparam int CODE_W = 13;
    localparam int SYN_W  = 4;
    localparam int DATA_W = 8;

    // 1-based Hamming positions of data bits d0..d7
    localparam int POS_D0 = 3;
    localparam int POS_D1 = 5;
    localparam int POS_D2 = 6;
    localparam int POS_D3 = 7;
    localparam int POS_D4 = 9;
    localparam int POS_D5 = 10;
    localparam int POS_D6 = 11;
    localparam int POS_D7 = 12;

    typedef enum logic [1:0] {
        CLEAN,
        SINGLE,
        DOUBLE
    } err_class_e;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [SYN_W-1:0]  syn;
        logic              ov;
        logic              par;
    } s1_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [SYN_W-1:0]  syn;
        logic              single;
        logic              dbl;
        logic              perr;
    } s2_t;

    function automatic logic [DATA_W-1:0] extract_data(
        input logic [CODE_W-1:0] code
    );
        return {code[POS_D7-1], code[POS_D6-1],
                code[POS_D5-1], code[POS_D4-1],
                code[POS_D3-1], code[POS_D2-1],
                code[POS_D1-1], code[POS_D0-1]};
    endfunction

endpackage

// File: rtl/composite_ecc_sat_counter.sv
// composite_ecc_sat_counter: up-counter that sticks at all-ones.
// Ports: clk, rst_n (async, active low), inc, clr (wins over inc), count.
module composite_ecc_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/composite_ecc_rx_pipe.sv
// composite_ecc_rx_pipe: 2-stage valid/ready SECDED(13,8) decoder with
// on-chip parity check and saturating error counters.
// Ports: in_valid/in_ready/in_code/in_parity in; out_valid/out_ready,
// out_data, out_single, out_double, out_parity_err, out_syndrome out;
// cnt_clear, cnt_corrected, cnt_uncorrectable; err_log_valid/err_log_code.
// Define COMPOSITE_ECC_ERR_LOG_EN to capture the first uncorrectable word.
module composite_ecc_rx_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [12:0]           in_code,
    input  logic                  in_parity,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_single,
    output logic                  out_double,
    output logic                  out_parity_err,
    output logic [3:0]            out_syndrome,
    input  logic                  cnt_clear,
    output logic [CNT_WIDTH-1:0]  cnt_corrected,
    output logic [CNT_WIDTH-1:0]  cnt_uncorrectable,
    output logic                  err_log_valid,
    output logic [12:0]           err_log_code
);

    import composite_ecc_pkg::*;

    if (DATA_WIDTH != 8) begin : g_width_chk
        $error("composite_ecc_rx_pipe: only DATA_WIDTH=8 is supported");
    end

    s1_t        s1_d, s1_q;
    s2_t        s2_d, s2_q;
    logic       s1_valid_q, s2_valid_q;
    logic       s1_ready, s2_ready, out_hs;
    err_class_e cls;
    logic [CODE_W-1:0] fixed;
    logic       syn_hit;

    assign s2_ready = !s2_valid_q || out_ready;
    assign s1_ready = !s1_valid_q || s2_ready;
    assign in_ready = s1_ready;
    assign out_hs   = s2_valid_q && out_ready;

    // syndrome bit k is the XOR over positions whose index has bit k set
    always_comb begin
        s1_d.code   = in_code;
        s1_d.par    = in_parity;
        s1_d.ov     = ^in_code;
        s1_d.syn[0] = in_code[0] ^ in_code[2] ^ in_code[4]
                    ^ in_code[6] ^ in_code[8] ^ in_code[10];
        s1_d.syn[1] = in_code[1] ^ in_code[2] ^ in_code[5]
                    ^ in_code[6] ^ in_code[9] ^ in_code[10];
        s1_d.syn[2] = in_code[3] ^ in_code[4] ^ in_code[5]
                    ^ in_code[6] ^ in_code[11];
        s1_d.syn[3] = in_code[7] ^ in_code[8] ^ in_code[9]
                    ^ in_code[10] ^ in_code[11];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else if (s1_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    always_comb begin
        syn_hit = (s1_q.syn != '0) && (s1_q.syn <= SYN_W'(12));
        cls     = DOUBLE;
        fixed   = s1_q.code;
        unique case (1'b1)
            (s1_q.syn == '0) && !s1_q.ov: cls = CLEAN;
            // only the overall parity bit flipped: data untouched
            (s1_q.syn == '0) && s1_q.ov:  cls = SINGLE;
            syn_hit && s1_q.ov: begin
                cls   = SINGLE;
                fixed = s1_q.code
                      ^ (CODE_W'(1) << (s1_q.syn - SYN_W'(1)));
            end
            default: cls = DOUBLE;
        endcase
        s2_d.data   = extract_data(fixed);
        s2_d.syn    = s1_q.syn;
        s2_d.single = (cls == SINGLE);
        s2_d.dbl    = (cls == DOUBLE);
        s2_d.perr   = (^s2_d.data) ^ s1_q.par;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
        end else if (s2_ready) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_q <= s2_d;
            end
        end
    end

    assign out_valid      = s2_valid_q;
    assign out_data       = s2_q.data;
    assign out_single     = s2_q.single;
    assign out_double     = s2_q.dbl;
    assign out_parity_err = s2_q.perr;
    assign out_syndrome   = s2_q.syn;

    composite_ecc_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_cnt_corr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_hs && s2_q.single),
        .clr   (cnt_clear),
        .count (cnt_corrected)
    );

    composite_ecc_sat_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_cnt_unc (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_hs && (s2_q.dbl || s2_q.perr)),
        .clr   (cnt_clear),
        .count (cnt_uncorrectable)
    );

`ifdef COMPOSITE_ECC_ERR_LOG_EN
    logic [CODE_W-1:0] s2_code_q;
    logic [CODE_W-1:0] log_code_q;
    logic              log_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_code_q <= '0;
        end else if (s2_ready && s1_valid_q) begin
            s2_code_q <= s1_q.code;
        end
    end

    // first uncorrectable word sticks until cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            log_valid_q <= 1'b0;
            log_code_q  <= '0;
        end else if (cnt_clear) begin
            log_valid_q <= 1'b0;
            log_code_q  <= '0;
        end else if (out_hs && s2_q.dbl && !log_valid_q) begin
            log_valid_q <= 1'b1;
            log_code_q  <= s2_code_q;
        end
    end

    assign err_log_valid = log_valid_q;
    assign err_log_code  = log_code_q;
`else
    assign err_log_valid = 1'b0;
    assign err_log_code  = '0;
`endif

endmodule
